// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side signal bundle for sync_fifo_param.
// master drives requests and data in; slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int ADDRESS = $clog2(DEPTH);

  logic               wr;
  logic [WIDTH-1:0]   data_in;
  logic               rd;
  logic               err_clr;
  logic [WIDTH-1:0]   data_out;
  logic               rd_valid;
  logic               full;
  logic               empty;
  logic               alm_full;
  logic               alm_empty;
  logic [ADDRESS:0]   count;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr, data_in, rd, err_clr,
    input  data_out, rd_valid, full, empty, alm_full, alm_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd, err_clr,
    output data_out, rd_valid, full, empty, alm_full, alm_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and standard or first-word-fall-through reads.
module sync_fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2,
  parameter bit FWFT  = 1'b0,
  localparam int ADDRESS = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);

  localparam logic [ADDRESS:0] DEPTH_C = DEPTH[ADDRESS:0];
  localparam logic [ADDRESS:0] AF_C    = AF_TH[ADDRESS:0];
  localparam logic [ADDRESS:0] AE_C    = AE_TH[ADDRESS:0];

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ADDRESS:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESS:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wr_acc, rd_acc;

  always_comb begin
    full        = (count_q == DEPTH_C);
    empty       = (count_q == '0);
    wr_acc      = bus.wr && !full;
    rd_acc      = bus.rd && !empty;
    wr_ptr_d    = wr_ptr_q + {{ADDRESS{1'b0}}, wr_acc};
    rd_ptr_d    = rd_ptr_q + {{ADDRESS{1'b0}}, rd_acc};
    // Pointer difference modulo 2*DEPTH equals count + wr_acc - rd_acc.
    count_d     = wr_ptr_d - rd_ptr_d;
    overflow_d  = (bus.wr && full)  || (overflow_q  && !bus.err_clr);
    underflow_d = (bus.rd && empty) || (underflow_q && !bus.err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDRESS-1:0]] <= bus.data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.data_out = mem_q[rd_ptr_q[ADDRESS-1:0]];
      assign bus.rd_valid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] data_q, data_d;
      logic             rd_valid_q, rd_valid_d;

      always_comb begin
        data_d     = data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) data_d = mem_q[rd_ptr_q[ADDRESS-1:0]];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          data_q     <= data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign bus.data_out = data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.alm_full  = (count_q >= AF_C);
  assign bus.alm_empty = (count_q <= AE_C);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT instance,
// each checked every cycle against a queue-based reference model.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst_s, rst_f;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) s_if ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) f_if ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_TH(14), .AE_TH(2), .FWFT(1'b0))
    u_std (.clk(clk), .reset(rst_s), .bus(s_if));

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_TH(14), .AE_TH(2), .FWFT(1'b1))
    u_fwft (.clk(clk), .reset(rst_f), .bus(f_if));

  // Standard-mode reference model
  int         mc = 0;
  bit         ovm = 1'b0, unm = 1'b0;
  logic [7:0] q[$];
  logic [7:0] last_d = 8'h00;

  // FWFT reference model
  int         mcf = 0;
  logic [7:0] qf[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_std_flags();
    chk("count",     32'(s_if.count), mc);
    chk("full",      s_if.full,       mc == 16);
    chk("empty",     s_if.empty,      mc == 0);
    chk("alm_full",  s_if.alm_full,   mc >= 14);
    chk("alm_empty", s_if.alm_empty,  mc <= 2);
    chk("overflow",  s_if.overflow,   ovm);
    chk("underflow", s_if.underflow,  unm);
  endtask

  task automatic scyc(input bit w, input logic [7:0] d, input bit r, input bit clr);
    bit wa, ra;
    s_if.wr = w; s_if.data_in = d; s_if.rd = r; s_if.err_clr = clr;
    wa  = w && (mc != 16);
    ra  = r && (mc != 0);
    ovm = (w && mc == 16) || (ovm && !clr);
    unm = (r && mc == 0)  || (unm && !clr);
    if (wa) q.push_back(d);
    mc = mc + int'(wa) - int'(ra);
    @(posedge clk); #1;
    s_if.wr = 1'b0; s_if.rd = 1'b0; s_if.err_clr = 1'b0;
    chk("rd_valid", s_if.rd_valid, ra);
    if (s_if.rd_valid && q.size() != 0) last_d = q.pop_front();
    chk("data_out", s_if.data_out, last_d);
    chk_std_flags();
  endtask

  task automatic fcyc(input bit w, input logic [7:0] d, input bit r);
    bit wa, ra;
    f_if.wr = w; f_if.data_in = d; f_if.rd = r; f_if.err_clr = 1'b0;
    wa = w && (mcf != 16);
    ra = r && (mcf != 0);
    if (wa) qf.push_back(d);
    if (ra) void'(qf.pop_front());
    mcf = mcf + int'(wa) - int'(ra);
    @(posedge clk); #1;
    f_if.wr = 1'b0; f_if.rd = 1'b0;
    chk("f_count",    32'(f_if.count), mcf);
    chk("f_empty",    f_if.empty,      mcf == 0);
    chk("f_rd_valid", f_if.rd_valid,   mcf != 0);
    if (mcf != 0) chk("f_data_out", f_if.data_out, qf[0]);
  endtask

  initial begin
    rst_s = 1'b1; rst_f = 1'b1;
    s_if.wr = 1'b0; s_if.rd = 1'b0; s_if.err_clr = 1'b0; s_if.data_in = '0;
    f_if.wr = 1'b0; f_if.rd = 1'b0; f_if.err_clr = 1'b0; f_if.data_in = '0;
    #12;
    chk("rst_data_out", s_if.data_out, 8'h00);
    chk("rst_rd_valid", s_if.rd_valid, 1'b0);
    chk_std_flags();
    #1;
    rst_s = 1'b0; rst_f = 1'b0;

    scyc(1'b0, 8'h00, 1'b0, 1'b0);
    scyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, overflow, clear, drain in order
    for (int i = 0; i < 16; i++) scyc(1'b1, 8'(i), 1'b0, 1'b0);
    scyc(1'b1, 8'hAA, 1'b0, 1'b0);
    scyc(1'b0, 8'h00, 1'b0, 1'b0);
    scyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) scyc(1'b0, 8'h00, 1'b1, 1'b0);
    scyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Empty-side errors and simultaneous access while empty
    scyc(1'b0, 8'h00, 1'b1, 1'b0);
    scyc(1'b1, 8'h55, 1'b1, 1'b0);
    scyc(1'b0, 8'h00, 1'b1, 1'b0);
    scyc(1'b0, 8'h00, 1'b1, 1'b1);
    scyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous access while full: read wins, write rejected
    for (int i = 0; i < 16; i++) scyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    scyc(1'b1, 8'hEE, 1'b1, 1'b0);
    scyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) scyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Steady-state at count 8 across pointer wrap
    for (int i = 0; i < 40; i++) scyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) scyc(1'b0, 8'h00, 1'b1, 1'b0);
    scyc(1'b0, 8'h00, 1'b0, 1'b0);

    // FWFT instance
    fcyc(1'b0, 8'h00, 1'b0);
    fcyc(1'b1, 8'h3C, 1'b0);
    fcyc(1'b0, 8'h00, 1'b0);
    fcyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) fcyc(1'b1, 8'(8'hC0 + i), 1'b0);
    fcyc(1'b1, 8'hD0, 1'b1);
    rst_f = 1'b1;
    #1;
    chk("f_rst_count", 32'(f_if.count), 0);
    chk("f_rst_empty", f_if.empty, 1'b1);
    qf.delete();
    mcf = 0;
    @(posedge clk); #1;
    rst_f = 1'b0;
    fcyc(1'b0, 8'h00, 1'b0);
    fcyc(1'b1, 8'h99, 1'b0);
    fcyc(1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Width and depth are configurable, and all DEPTH entries are usable.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable standard or first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- ADDRESS, $clog2(DEPTH), pointer index width; derived, not overridden.
- AF_TH, DEPTH-2, almost_full asserts when count >= AF_TH (1..DEPTH).
- AE_TH, 2, almost_empty asserts when count <= AE_TH (0..DEPTH-1).
- FWFT, 0, 0 = standard 1-cycle read latency; 1 = head word presented on data_out while not empty.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write request.
- data_in  input  WIDTH  write data.
- rd  input  1  read request (FWFT: pop/acknowledge of the head word).
- err_clr  input  1  synchronous clear of the sticky error flags.
- data_out  output  WIDTH  read data.
- rd_valid  output  1  standard mode: data_out updated this cycle; FWFT: equals !empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- alm_full  output  1  count >= AF_TH.
- alm_empty  output  1  count <= AE_TH.
- count  output  ADDRESS+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset, asynchronous on reset=1:
  - wr_ptr, rd_ptr, count and data_out go to 0.
  - rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Flags then read empty=1, full=0, alm_empty=1, alm_full=0.
  - Reset asserted mid-operation discards all stored data immediately.
- Pointers are ADDRESS+1 bits wide, and the MSB is the wrap bit. The memory index is ptr[ADDRESS-1:0]. Pointers wrap naturally modulo 2*DEPTH.
- Write accepted iff wr && !full. On accept: memory[wr_ptr] <= data_in, then wr_ptr+1.
- Read accepted iff rd && !empty. On accept: rd_ptr+1.
- Standard mode read:
  - data_out <= memory[rd_ptr] on accept, and rd_valid=1 the following cycle.
  - Otherwise data_out holds its value and rd_valid=0.
- FWFT mode read:
  - data_out = memory[rd_ptr[ADDRESS-1:0]], from an asynchronous memory read.
  - data_out is valid whenever empty=0. rd consumes the displayed word.
- count update:
  - Registered, count <= count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- Flags are combinational decodes of the registered count. They change in the cycle after the accepted operation.
- Simultaneous wr and rd:
  - When full: the read is accepted; the write is rejected, because full is evaluated before the read; overflow is set.
  - When empty: the write is accepted; the read is rejected; underflow is set. The written word is readable next cycle (FWFT: visible next cycle).
  - Otherwise both are accepted.
- Error flags:
  - overflow <= 1 on wr && full; underflow <= 1 on rd && empty.
  - err_clr=1 clears both flags, but a same-cycle new error has priority and keeps the flag set.
- Rejected operations do not change pointers, memory, count or data_out.
- Threshold flags are independent of full/empty. With AF_TH=DEPTH, alm_full equals full.

Test Plan (WIDTH=8, DEPTH=16, AF_TH=14, AE_TH=2):
- Reset then idle -> empty=1, alm_empty=1, full=0, count=0, data_out=0x00, overflow=0, underflow=0.
- Write 0x00..0x0F on 16 consecutive cycles -> full=1 after the 16th write; count=16; alm_full=1 from count=14; then 16 reads (FWFT=0) return 0x00..0x0F in order, each with rd_valid=1 one cycle after rd; empty=1 at the end.
- Full FIFO, wr=1 with data 0xAA -> write rejected, overflow=1 sticky, count stays 16; err_clr=1 for one cycle -> overflow=0.
- Empty FIFO, rd=1 -> underflow=1, data_out unchanged, rd_valid=0; same cycle wr=1 0x55 -> count=1 and a subsequent read returns 0x55.
- Pointer wrap: 40 write/read pairs with count held at 8, using simultaneous wr+rd -> count stays 8 and data order is preserved across pointer wrap (ptr MSB toggles).
- FWFT=1: write 0x3C into an empty FIFO -> the next cycle empty=0, data_out=0x3C without rd; rd=1 -> empty=1. Assert reset mid-stream at count=5 -> count=0 and empty=1 immediately, without waiting for a clock edge.
